aib_avmm_cmd_bridge: RTL and testbench
======================================

// Module: aib_avmm_cmd_bridge
// PURPOSE
//  Upstream AVMM master that feeds the channel configuration decoder (cfg_avmm_* slave).
//  Accepts register commands on a valid/ready port and buffers them in a small FIFO.
//  Runs each command as a single AVMM transaction: honours waitrequest and waits for readdatavalid.
//  Returns exactly one response per command. A timeout turns a missing slave ack into an error response.
// PARAMETERS
//  CMD_DEPTH  4    command FIFO entries; power of 2, >=2
//  TIMEOUT    255  max cycles waited in REQ or RDWAIT before error; 1..2^TO_W-1
//  TO_W       8    timeout counter width
// PORTS
//  clk            in   1   single clock for all logic
//  reset          in   1   synchronous, active-high
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   command FIFO not full
//  cmd_write      in   1   1=write, 0=read
//  cmd_addr       in   17  {addr_id[5:0], offset[10:0]}
//  cmd_wdata      in   32  write data
//  cmd_byte_en    in   4   byte enables
//  rsp_valid      out  1   response available
//  rsp_ready      in   1   response consumed
//  rsp_write      out  1   echo of cmd_write
//  rsp_rdata      out  32  read data; 0 for writes and errors
//  rsp_err        out  1   transaction timed out
//  avmm_write     out  1   to cfg_avmm_write
//  avmm_read      out  1   to cfg_avmm_read
//  avmm_addr      out  17  to cfg_avmm_addr
//  avmm_wdata     out  32  to cfg_avmm_wdata
//  avmm_byte_en   out  4   to cfg_avmm_byte_en
//  avmm_rdata     in   32  from cfg_avmm_rdata
//  avmm_rdatavld  in   1   from cfg_avmm_rdatavld
//  avmm_waitreq   in   1   from cfg_avmm_waitreq
//  busy           out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  - Reset: FIFO empty, FSM=IDLE, timeout counter=0. Next edge: all outputs 0 except cmd_ready=1.
//  - FIFO: push on cmd_valid&cmd_ready. cmd_ready=!full (registered count, no bypass).
//    Pop only in IDLE when non-empty. Push and pop in the same cycle are both honoured; count is unchanged.
//    A push into an empty FIFO is not popped in the same cycle.
//  - All avmm_* and rsp_* outputs are registered.
//    Handshake in cycle N into an empty idle bridge -> avmm_read/avmm_write high in cycle N+2.
//  - FSM states:
//    IDLE: FIFO non-empty -> pop, load avmm_* from the entry, assert read or write -> REQ. Counter=0.
//    REQ: hold addr/data/be/strobe stable while avmm_waitreq=1; counter increments each cycle.
//      On waitreq=0, drop the strobe on the next edge.
//      Write: -> RESP, err=0.
//      Read: if avmm_rdatavld is also high this cycle, capture rdata -> RESP. Otherwise -> RDWAIT, counter=0.
//      Counter reaching TIMEOUT with waitreq still 1 -> drop strobe, -> RESP with err=1 and rdata=0.
//    RDWAIT: capture avmm_rdata on avmm_rdatavld -> RESP. Counter reaching TIMEOUT -> RESP with err=1 and rdata=0.
//    RESP: rsp_valid=1 with stable fields until rsp_ready. On handshake: rsp_valid=0 next edge, -> IDLE.
//  - Only one outstanding AVMM transaction; no new request until the response is consumed.
//  - Throughput: a write with waitreq=0 and rsp_ready=1 takes 3 cycles per command.
//  - avmm_rdatavld outside REQ/RDWAIT is ignored and rdata is not sampled.
//  - avmm_read and avmm_write are never both 1.
//  - Out-of-range addresses are not filtered here; the slave never acks them, so they time out.
//  - Reset mid-operation: strobes drop at the next edge. Queued and in-flight commands are discarded with no response.
//  - A late rdatavld arriving after a timeout is ignored.
// TESTING
//  1. Write 0x0000_0201 data 0xA5A5_5A5A be=0xF, waitreq=0 -> avmm_write 1 cycle at N+2; rsp_err=0, rsp_write=1.
//  2. Read 0x0301, waitreq=1 for 3 cycles, rdatavld 2 cycles later with 0x1234_5678 -> strobe held 4 cycles; rsp_rdata=0x1234_5678.
//  3. Read with TIMEOUT=8 and no rdatavld -> rsp_err=1, rsp_rdata=0. A late rdatavld is ignored and the next command runs normally.
//  4. 6 back-to-back commands, rsp_ready=0, CMD_DEPTH=4 -> cmd_ready low after 4 queued plus 1 in flight; responses come in order, none lost.
//  5. Read with waitreq=0 and rdatavld in the same cycle, data 0xDEAD_BEEF -> goes straight to RESP with the data captured.
//  6. Assert reset during RDWAIT with 2 queued -> strobes 0, busy=0, cmd_ready=1 next edge; no rsp_valid.

Source files
------------

// File: rtl/aib_avmm_cmd_bridge.sv
// Command-to-AVMM bridge: queues register commands and runs each one as a single
// AVMM transaction, returning exactly one response (an error if the slave never acks).
module aib_avmm_cmd_bridge #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [16:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_byte_en,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [16:0] avmm_addr,
  output logic [31:0] avmm_wdata,
  output logic [3:0]  avmm_byte_en,
  input  logic [31:0] avmm_rdata,
  input  logic        avmm_rdatavld,
  input  logic        avmm_waitreq,
  output logic        busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 1 + 17 + 32 + 4;
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(CMD_DEPTH);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} state_t;

  logic [EW-1:0] mem_q [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push, pop;
  logic [EW-1:0] head;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic        avmm_write_q, avmm_write_d;
  logic        avmm_read_q, avmm_read_d;
  logic [16:0] avmm_addr_q, avmm_addr_d;
  logic [31:0] avmm_wdata_q, avmm_wdata_d;
  logic [3:0]  avmm_byte_en_q, avmm_byte_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Ready comes only from the registered count, so a full queue never accepts even while popping.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_byte_en};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    avmm_write_d   = avmm_write_q;
    avmm_read_d    = avmm_read_q;
    avmm_addr_d    = avmm_addr_q;
    avmm_wdata_d   = avmm_wdata_q;
    avmm_byte_en_d = avmm_byte_en_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_write_d    = rsp_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d        = REQ;
          cnt_d          = '0;
          avmm_write_d   = head[EW-1];
          avmm_read_d    = ~head[EW-1];
          avmm_addr_d    = head[52:36];
          avmm_wdata_d   = head[35:4];
          avmm_byte_en_d = head[3:0];
          rsp_write_d    = head[EW-1];
        end
      end
      REQ: begin
        if (!avmm_waitreq) begin
          avmm_write_d = 1'b0;
          avmm_read_d  = 1'b0;
          if (avmm_write_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else if (avmm_rdatavld) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = avmm_rdata;
          end else begin
            state_d = RDWAIT;
            cnt_d   = '0;
          end
        end else if (cnt_inc == TO_MAX) begin
          avmm_write_d = 1'b0;
          avmm_read_d  = 1'b0;
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_rdata_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RDWAIT: begin
        if (avmm_rdatavld) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = avmm_rdata;
        end else if (cnt_inc == TO_MAX) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      avmm_write_q   <= 1'b0;
      avmm_read_q    <= 1'b0;
      avmm_addr_q    <= '0;
      avmm_wdata_q   <= '0;
      avmm_byte_en_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      avmm_write_q   <= avmm_write_d;
      avmm_read_q    <= avmm_read_d;
      avmm_addr_q    <= avmm_addr_d;
      avmm_wdata_q   <= avmm_wdata_d;
      avmm_byte_en_q <= avmm_byte_en_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign avmm_write   = avmm_write_q;
  assign avmm_read    = avmm_read_q;
  assign avmm_addr    = avmm_addr_q;
  assign avmm_wdata   = avmm_wdata_q;
  assign avmm_byte_en = avmm_byte_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_aib_avmm_cmd_bridge.sv
// Directed bench for aib_avmm_cmd_bridge with TIMEOUT=8 and a four-entry command queue.
module tb_aib_avmm_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [16:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_byte_en;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        avmm_write, avmm_read;
  logic [16:0] avmm_addr;
  logic [31:0] avmm_wdata;
  logic [3:0]  avmm_byte_en;
  logic [31:0] avmm_rdata;
  logic        avmm_rdatavld, avmm_waitreq;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rw_both  = 0;

  aib_avmm_cmd_bridge #(.CMD_DEPTH(4), .TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byte_en(cmd_byte_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avmm_write(avmm_write), .avmm_read(avmm_read), .avmm_addr(avmm_addr),
    .avmm_wdata(avmm_wdata), .avmm_byte_en(avmm_byte_en),
    .avmm_rdata(avmm_rdata), .avmm_rdatavld(avmm_rdatavld),
    .avmm_waitreq(avmm_waitreq), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (avmm_read && avmm_write) rw_both++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [16:0] addr, input logic [31:0] data);
    check_val("push_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_byte_en = 4'hF;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, s, sent, got;
    logic rdy, rv;
    logic [31:0] rd;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_byte_en = '0; rsp_ready = 1'b0; avmm_rdata = '0; avmm_rdatavld = 1'b0; avmm_waitreq = 1'b0;
    tick(); tick();
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_strobes", {30'd0, avmm_read, avmm_write}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: write with no wait states
    push(1'b1, 17'h00201, 32'hA5A5_5A5A);
    check_val("wr_n1_idle", {31'd0, avmm_write}, 32'd0);
    tick();
    check_val("wr_n2_strobe", {31'd0, avmm_write}, 32'd1);
    check_val("wr_addr", {15'd0, avmm_addr}, 32'h201);
    check_val("wr_wdata", avmm_wdata, 32'hA5A5_5A5A);
    check_val("wr_be", {28'd0, avmm_byte_en}, 32'hF);
    tick();
    check_val("wr_strobe_drop", {31'd0, avmm_write}, 32'd0);
    check_val("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
    check_val("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_val("wr_rsp_rdata", rsp_rdata, 32'd0);
    consume();

    // 2: read, waitreq for 3 cycles, data 2 cycles after strobe drops
    push(1'b0, 17'h00301, 32'd0);
    avmm_waitreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rd_strobe_held", {31'd0, avmm_read}, 32'd1);
      if (i == 3) avmm_waitreq = 1'b0;
    end
    tick();
    check_val("rd_strobe_drop", {31'd0, avmm_read}, 32'd0);
    check_val("rd_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    avmm_rdatavld = 1'b1; avmm_rdata = 32'h1234_5678;
    tick();
    avmm_rdatavld = 1'b0;
    check_val("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check_val("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_val("rd_rsp_write", {31'd0, rsp_write}, 32'd0);
    consume();

    // 3a: read acked but data never returned -> times out in RDWAIT
    push(1'b0, 17'h007FF, 32'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check_val("to_rdwait_cycles", n, 32'd10);
    check_val("to_rdwait_err", {31'd0, rsp_err}, 32'd1);
    check_val("to_rdwait_rdata", rsp_rdata, 32'd0);
    avmm_rdatavld = 1'b1; avmm_rdata = 32'hFFFF_FFFF;
    tick();
    avmm_rdatavld = 1'b0;
    check_val("late_vld_rdata", rsp_rdata, 32'd0);
    check_val("late_vld_err", {31'd0, rsp_err}, 32'd1);
    consume();
    avmm_rdatavld = 1'b1;
    tick();
    avmm_rdatavld = 1'b0;
    check_val("idle_vld_busy", {31'd0, busy}, 32'd0);
    check_val("idle_vld_rsp", {31'd0, rsp_valid}, 32'd0);

    // 3b: slave never drops waitreq -> strobe held TIMEOUT cycles
    avmm_waitreq = 1'b1;
    push(1'b0, 17'h1FFFF, 32'd0);
    n = 0; s = 0;
    while (!rsp_valid && n < 50) begin
      tick(); n++;
      if (avmm_read) s++;
    end
    avmm_waitreq = 1'b0;
    check_val("to_req_cycles", n, 32'd9);
    check_val("to_req_strobes", s, 32'd8);
    check_val("to_req_err", {31'd0, rsp_err}, 32'd1);
    check_val("to_req_strobe_off", {31'd0, avmm_read}, 32'd0);
    consume();

    // 5: zero-wait read with data in the same cycle
    push(1'b0, 17'h00401, 32'd0);
    tick();
    check_val("fast_rd_strobe", {31'd0, avmm_read}, 32'd1);
    avmm_rdatavld = 1'b1; avmm_rdata = 32'hDEAD_BEEF;
    tick();
    avmm_rdatavld = 1'b0;
    check_val("fast_rd_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("fast_rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_val("fast_rd_err", {31'd0, rsp_err}, 32'd0);
    consume();

    // 4: six back-to-back reads with responses blocked; slave echoes the address
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      avmm_rdatavld = avmm_read;
      avmm_rdata    = 32'hC0DE_0000 | {15'd0, avmm_addr};
      cmd_valid     = (sent < 6);
      cmd_write     = 1'b0;
      cmd_addr      = 17'h10 + 17'(sent);
      rsp_ready     = (cyc >= 10);
      if (cyc == 10) begin
        check_val("q_accepted", sent, 32'd5);
        check_val("q_full_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("q_busy", {31'd0, busy}, 32'd1);
      end
      rdy = cmd_ready; rv = rsp_valid; rd = rsp_rdata;
      tick();
      if (rdy && cmd_valid) sent++;
      if (rv && rsp_ready) begin
        check_val("q_rsp_order", rd, 32'hC0DE_0010 + 32'(got));
        got++;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; avmm_rdatavld = 1'b0;
    check_val("q_rsp_count", got, 32'd6);
    tick();
    check_val("q_drained_busy", {31'd0, busy}, 32'd0);

    // 6: reset while in RDWAIT with two commands queued
    cmd_write = 1'b0; cmd_byte_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_addr = 17'h20 + 17'(i);
      tick();
    end
    cmd_valid = 1'b0;
    check_val("mid_busy", {31'd0, busy}, 32'd1);
    check_val("mid_queue_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_strobes", {30'd0, avmm_read, avmm_write}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    s = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || avmm_read || avmm_write) s++;
    end
    check_val("mid_rst_discard", s, 32'd0);

    check_val("rw_exclusive", rw_both, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
